// File: rtl/count_seq_checker.sv
// Sequence monitor for a WIDTH-bit up-counter stream: locks after SYNC_LEN good steps, then flags/counts breaks and wraps.
// Optional macro RESYNC_ZERO_EN: while locked, an unexpected 0 is a tolerated counter restart counted in rst_cnt.
module count_seq_checker #(
  parameter int WIDTH    = 5,
  parameter int SYNC_LEN = 2,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             smp_en,
  input  logic [WIDTH-1:0] q_in,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt,
  output logic             wrap_pulse,
  output logic [ERR_W-1:0] wrap_cnt,
  output logic [ERR_W-1:0] rst_cnt
);

  localparam int GOOD_W = (SYNC_LEN < 2) ? 1 : $clog2(SYNC_LEN + 1);
  localparam logic [GOOD_W-1:0] SYNC_TGT = GOOD_W'(SYNC_LEN);

  typedef enum logic [1:0] {IDLE, SYNC, LOCK} state_t;

  state_t             state, state_nx;
  logic [WIDTH-1:0]   expected, expected_nx;
  logic [GOOD_W-1:0]  good, good_nx, good_inc;
  logic               match;
  logic               err_nx, wrap_nx;
  logic [ERR_W-1:0]   err_cnt_nx, wrap_cnt_nx;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign match    = (q_in == expected);
  assign good_inc = good + 1'b1;
  assign locked   = (state == LOCK);

`ifdef RESYNC_ZERO_EN
  logic restart;
  logic [ERR_W-1:0] rst_cnt_q;

  // A mismatching 0 while locked is treated as the counter having been reset.
  assign restart = smp_en && (state == LOCK) && !match && (q_in == '0);
  assign rst_cnt = rst_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset)       rst_cnt_q <= '0;
    else if (restart) rst_cnt_q <= sat_inc(rst_cnt_q);
  end
`else
  logic restart;
  assign restart = 1'b0;
  assign rst_cnt = '0;
`endif

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      expected   <= '0;
      good       <= '0;
      err_pulse  <= 1'b0;
      wrap_pulse <= 1'b0;
      err_cnt    <= '0;
      wrap_cnt   <= '0;
    end else begin
      state      <= state_nx;
      expected   <= expected_nx;
      good       <= good_nx;
      err_pulse  <= err_nx;
      wrap_pulse <= wrap_nx;
      err_cnt    <= err_cnt_nx;
      wrap_cnt   <= wrap_cnt_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx    = state;
    expected_nx = expected;
    good_nx     = good;
    if (smp_en) begin
      case (state)
        IDLE: begin
          expected_nx = q_in + 1'b1;
          good_nx     = '0;
          state_nx    = SYNC;
        end
        SYNC: begin
          expected_nx = q_in + 1'b1;
          if (match) begin
            good_nx = good_inc;
            if (good_inc == SYNC_TGT) state_nx = LOCK;
          end else begin
            good_nx = '0;
          end
        end
        LOCK: begin
          if (match) begin
            expected_nx = q_in + 1'b1;
          end else if (restart) begin
            expected_nx = WIDTH'(1);
          end else begin
            expected_nx = q_in + 1'b1;
            good_nx     = '0;
            state_nx    = SYNC;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Output / counter logic
  always_comb begin
    err_nx      = 1'b0;
    wrap_nx     = 1'b0;
    err_cnt_nx  = err_cnt;
    wrap_cnt_nx = wrap_cnt;
    if (smp_en && state == LOCK) begin
      if (match) begin
        if (q_in == '0) begin
          wrap_nx     = 1'b1;
          wrap_cnt_nx = sat_inc(wrap_cnt);
        end
      end else if (!restart) begin
        err_nx     = 1'b1;
        err_cnt_nx = sat_inc(err_cnt);
      end
    end
  end

endmodule

// File: tb/tb_count_seq_checker.sv
// Directed bench for count_seq_checker: default instance plus an ERR_W=2 instance for saturation.
module tb_count_seq_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       smp_en = 1'b0;
  logic [4:0] q_in = '0;

  logic       locked, err_pulse, wrap_pulse;
  logic [7:0] err_cnt, wrap_cnt, rst_cnt;
  logic       locked2, err_pulse2, wrap_pulse2;
  logic [1:0] err_cnt2, wrap_cnt2, rst_cnt2;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  count_seq_checker #(.WIDTH(5), .SYNC_LEN(2), .ERR_W(8)) dut (
    .clk(clk), .reset(reset), .smp_en(smp_en), .q_in(q_in),
    .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt),
    .wrap_pulse(wrap_pulse), .wrap_cnt(wrap_cnt), .rst_cnt(rst_cnt)
  );

  count_seq_checker #(.WIDTH(5), .SYNC_LEN(2), .ERR_W(2)) dut2 (
    .clk(clk), .reset(reset), .smp_en(smp_en), .q_in(q_in),
    .locked(locked2), .err_pulse(err_pulse2), .err_cnt(err_cnt2),
    .wrap_pulse(wrap_pulse2), .wrap_cnt(wrap_cnt2), .rst_cnt(rst_cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic sample(input logic [4:0] v);
    @(negedge clk);
    smp_en = 1'b1;
    q_in   = v;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [4:0] v);
    @(negedge clk);
    smp_en = 1'b0;
    q_in   = v;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset  = 1'b0;
    smp_en = 1'b1;
    q_in   = 5'd7;
    @(posedge clk);
    #1;
    @(negedge clk);
    reset  = 1'b1;
    smp_en = 1'b0;
  endtask

  initial begin
    // 1: reset held low with sampling enabled
    reset = 1'b0; smp_en = 1'b1; q_in = 5'd9;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_locked", locked, 0);
    chk("rst_err_pulse", err_pulse, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_wrap_pulse", wrap_pulse, 0);
    chk("rst_wrap_cnt", wrap_cnt, 0);
    chk("rst_rst_cnt", rst_cnt, 0);
    @(negedge clk);
    reset = 1'b1; smp_en = 1'b0;

    // 2: acquire lock
    sample(5'd3);  chk("acq3_locked", locked, 0);
    sample(5'd4);  chk("acq4_locked", locked, 0);
    sample(5'd5);  chk("acq5_locked", locked, 1);
    sample(5'd6);  chk("acq6_locked", locked, 1);
    chk("acq_err_cnt", err_cnt, 0);

    // 3: wrap while locked
    do_reset();
    sample(5'd27); sample(5'd28); sample(5'd29);
    chk("wr_lock", locked, 1);
    sample(5'd30); chk("wr30_pulse", wrap_pulse, 0);
    sample(5'd31); chk("wr31_pulse", wrap_pulse, 0);
    sample(5'd0);  chk("wr0_pulse", wrap_pulse, 1);
    chk("wr0_cnt", wrap_cnt, 1);
    chk("wr0_locked", locked, 1);
    sample(5'd1);  chk("wr1_pulse", wrap_pulse, 0);
    chk("wr1_cnt", wrap_cnt, 1);

    // 4: break and relock
    do_reset();
    sample(5'd7); sample(5'd8); sample(5'd9);
    sample(5'd12);
    chk("brk_err_pulse", err_pulse, 1);
    chk("brk_err_cnt", err_cnt, 1);
    chk("brk_locked", locked, 0);
    sample(5'd13);
    chk("brk13_err_pulse", err_pulse, 0);
    chk("brk13_locked", locked, 0);
    sample(5'd14);
    chk("brk14_locked", locked, 1);
    chk("brk14_err_cnt", err_cnt, 1);

    // 5: unexpected zero while locked
    do_reset();
    sample(5'd15); sample(5'd16); sample(5'd17);
    sample(5'd0);
`ifdef RESYNC_ZERO_EN
    chk("z_rst_cnt", rst_cnt, 1);
    chk("z_err_cnt", err_cnt, 0);
    chk("z_err_pulse", err_pulse, 0);
    chk("z_locked", locked, 1);
    sample(5'd1);
    chk("z1_locked", locked, 1);
    chk("z1_err_cnt", err_cnt, 0);
`else
    chk("z_err_cnt", err_cnt, 1);
    chk("z_err_pulse", err_pulse, 1);
    chk("z_locked", locked, 0);
    chk("z_rst_cnt", rst_cnt, 0);
`endif

    // 6: hold with smp_en low, then reset mid-lock
    do_reset();
    sample(5'd29); sample(5'd30); sample(5'd31);
    for (int i = 0; i < 5; i++) begin
      idle(5'(i * 7 + 3));
      chk("hold_locked", locked, 1);
      chk("hold_err_pulse", err_pulse, 0);
    end
    sample(5'd0);
    chk("hold_wrap_pulse", wrap_pulse, 1);
    chk("hold_wrap_cnt", wrap_cnt, 1);
    idle(5'd0);
    chk("idle_wrap_pulse", wrap_pulse, 0);
    chk("idle_wrap_cnt", wrap_cnt, 1);
    sample(5'd5);
    chk("hold_err_cnt", err_cnt, 1);
    @(negedge clk);
    reset = 1'b0; smp_en = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_locked", locked, 0);
    chk("mid_rst_err_cnt", err_cnt, 0);
    chk("mid_rst_wrap_cnt", wrap_cnt, 0);
    chk("mid_rst_err_pulse", err_pulse, 0);
    @(negedge clk);
    reset = 1'b1;

    // 7: five locked mismatches, narrow counter saturates
    sample(5'd1); sample(5'd2); sample(5'd3);
    sample(5'd10); sample(5'd11); sample(5'd12);
    sample(5'd20); sample(5'd21); sample(5'd22);
    sample(5'd30); sample(5'd31); sample(5'd0);
    sample(5'd5);  sample(5'd6);  sample(5'd7);
    chk("sat_pre_locked", locked2, 1);
    sample(5'd15);
    chk("sat_err_cnt8", err_cnt, 5);
    chk("sat_err_cnt2", err_cnt2, 3);
    chk("sat_err_pulse2", err_pulse2, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
